store_buffer: RTL



---
 rtl/store_buffer_pkg.sv | 13 +
 rtl/sb_fwd_search.sv | 58 +++++
 rtl/store_buffer.sv | 109 ++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared sizing constants for the commit-side store buffer and its forwarding search.
package store_buffer_pkg;

    localparam int SB_DEPTH    = 4;
    localparam int SB_SEL      = $clog2(SB_DEPTH);
    localparam int SB_PTR      = SB_SEL + 1;
    localparam int SB_ADDR_LEN = 32;
    localparam int SB_DATA_LEN = 32;
    localparam int SB_LANES    = 4;

    localparam logic [SB_LANES-1:0] SB_MASK_FULL = 4'hF;

endpackage

// File: rtl/sb_fwd_search.sv
// Youngest-match search over the occupied window head..tail-1 for store-to-load forwarding.
module sb_fwd_search
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH    = SB_DEPTH,
    parameter  int ADDR_LEN = SB_ADDR_LEN,
    parameter  int DATA_LEN = SB_DATA_LEN,
    localparam int SEL      = $clog2(DEPTH),
    localparam int PTR      = SEL + 1
) (
    input  logic [ADDR_LEN-1:0] entry_addr [DEPTH],
    input  logic [DATA_LEN-1:0] entry_data [DEPTH],
    input  logic [SB_LANES-1:0] entry_mask [DEPTH],
    input  logic [PTR-1:0]      head,
    input  logic [PTR-1:0]      tail,
    input  logic [ADDR_LEN-1:0] ld_addr,
    output logic                fwd_hit,
    output logic                fwd_conflict,
    output logic [DATA_LEN-1:0] fwd_data
);

    logic [PTR-1:0]      occ_s;
    logic [SEL-1:0]      idx_s [DEPTH];
    logic [DEPTH-1:0]    match_s;
    logic                found_s;
    logic [SB_LANES-1:0] sel_mask_s;
    logic [DATA_LEN-1:0] sel_data_s;

    assign occ_s = tail - head;

    // Slot g is the g-th oldest entry; compare word addresses only (byte offset shifted out).
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign idx_s[g]   = head[SEL-1:0] + SEL'(g);
        assign match_s[g] = (PTR'(g) < occ_s) &&
                            ((entry_addr[idx_s[g]] >> 2'd2) == (ld_addr >> 2'd2));
    end

    // Priority select: later (younger) matches override older ones.
    always_comb begin
        found_s    = 1'b0;
        sel_mask_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match_s[i]) begin
                found_s    = 1'b1;
                sel_mask_s = entry_mask[idx_s[i]];
                sel_data_s = entry_data[idx_s[i]];
            end else begin
                found_s    = found_s;
            end
        end
    end

    assign fwd_hit      = found_s && (sel_mask_s == SB_MASK_FULL);
    assign fwd_conflict = found_s && (sel_mask_s != SB_MASK_FULL);
    assign fwd_data     = sel_data_s;

endmodule

// File: rtl/store_buffer.sv
// Commit-side store buffer: in-order drain of ROB-committed stores, load forwarding, mispredict flush.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH    = SB_DEPTH,
    parameter  int ADDR_LEN = SB_ADDR_LEN,
    parameter  int DATA_LEN = SB_DATA_LEN,
    localparam int SEL      = $clog2(DEPTH),
    localparam int PTR      = SEL + 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                alloc_valid_i,
    input  logic [ADDR_LEN-1:0] alloc_addr_i,
    input  logic [DATA_LEN-1:0] alloc_data_i,
    input  logic [SB_LANES-1:0] alloc_mask_i,
    output logic                alloc_ready_o,
    input  logic                store_commit_i,
    input  logic                prmiss_i,
    output logic                mem_req_valid_o,
    output logic [ADDR_LEN-1:0] mem_req_addr_o,
    output logic [DATA_LEN-1:0] mem_req_data_o,
    output logic [SB_LANES-1:0] mem_req_mask_o,
    input  logic                mem_req_ready_i,
    input  logic [ADDR_LEN-1:0] ld_addr_i,
    output logic                ld_fwd_hit_o,
    output logic [DATA_LEN-1:0] ld_fwd_data_o,
    output logic                ld_conflict_o,
    output logic [PTR-1:0]      count_o,
    output logic                empty_o
);

    logic [ADDR_LEN-1:0] addr_r [DEPTH];
    logic [DATA_LEN-1:0] data_r [DEPTH];
    logic [SB_LANES-1:0] mask_r [DEPTH];
    logic [PTR-1:0]      head_r, com_r, tail_r;
    logic [PTR-1:0]      count_s, com_next_s, tail_next_s;
    logic                full_s, alloc_fire_s, commit_fire_s, drain_fire_s;

    assign count_s       = tail_r - head_r;
    assign full_s        = (count_s == PTR'(DEPTH));
    assign alloc_fire_s  = alloc_valid_i && !full_s && !prmiss_i;
    assign commit_fire_s = store_commit_i && (com_r != tail_r);
    assign drain_fire_s  = (head_r != com_r) && mem_req_ready_i;

    // Next commit/tail pointers; a flush rewinds tail to the post-commit boundary.
    always_comb begin
        com_next_s  = com_r + PTR'(commit_fire_s);
        tail_next_s = tail_r;
        if (prmiss_i) begin
            tail_next_s = com_next_s;
        end else begin
            tail_next_s = tail_r + PTR'(alloc_fire_s);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_r <= '0;
            com_r  <= '0;
            tail_r <= '0;
        end else begin
            head_r <= head_r + PTR'(drain_fire_s);
            com_r  <= com_next_s;
            tail_r <= tail_next_s;
        end
    end

    // Entry storage, written at the tail slot on an accepted allocation.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= '0;
                data_r[i] <= '0;
                mask_r[i] <= '0;
            end
        end else if (alloc_fire_s) begin
            addr_r[tail_r[SEL-1:0]] <= alloc_addr_i;
            data_r[tail_r[SEL-1:0]] <= alloc_data_i;
            mask_r[tail_r[SEL-1:0]] <= alloc_mask_i;
        end
    end

    assign alloc_ready_o   = !full_s;
    assign mem_req_valid_o = (head_r != com_r);
    assign mem_req_addr_o  = addr_r[head_r[SEL-1:0]];
    assign mem_req_data_o  = data_r[head_r[SEL-1:0]];
    assign mem_req_mask_o  = mask_r[head_r[SEL-1:0]];
    assign count_o         = count_s;
    assign empty_o         = (count_s == '0);

    sb_fwd_search #(
        .DEPTH    (DEPTH),
        .ADDR_LEN (ADDR_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_fwd (
        .entry_addr   (addr_r),
        .entry_data   (data_r),
        .entry_mask   (mask_r),
        .head         (head_r),
        .tail         (tail_r),
        .ld_addr      (ld_addr_i),
        .fwd_hit      (ld_fwd_hit_o),
        .fwd_conflict (ld_conflict_o),
        .fwd_data     (ld_fwd_data_o)
    );

endmodule
